// File: rtl/bp_pkg.sv
// Shared types and bit positions for the branch resolve/update path.
package bp_pkg;

  localparam int unsigned PRED_TAKEN_BIT = 1;
  localparam int unsigned BTB_VALID_BIT  = 0;
  localparam int unsigned WEN_BTB        = 0;
  localparam int unsigned WEN_BHT        = 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  pred;
    logic [31:0] pred_target;
    logic        hit;
  } pred_meta_t;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-side, pipeline-control, EX-outcome and predictor-update signals of the resolve unit.
interface branch_resolve_unit_if #(
  parameter int unsigned CNT_W = 32
);

  logic             if_valid;
  logic [31:0]      if_pc;
  logic [1:0]       if_pred;
  logic [31:0]      if_pred_target;
  logic             if_hit;
  logic             stall_id;
  logic             stall_ex;
  logic             flush_id;
  logic             flush_ex;
  logic             ex_is_br;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [1:0]       w_en;
  logic             br_in;
  logic [31:0]      w_br_pc;
  logic [31:0]      w_br_target;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output if_valid, if_pc, if_pred, if_pred_target, if_hit,
    output stall_id, stall_ex, flush_id, flush_ex,
    output ex_is_br, ex_taken, ex_target,
    input  mispredict, redirect_pc, w_en, br_in, w_br_pc, w_br_target, br_cnt, miss_cnt
  );

  modport slave (
    input  if_valid, if_pc, if_pred, if_pred_target, if_hit,
    input  stall_id, stall_ex, flush_id, flush_ex,
    input  ex_is_br, ex_taken, ex_target,
    output mispredict, redirect_pc, w_en, br_in, w_br_pc, w_br_target, br_cnt, miss_cnt
  );

endinterface

// File: rtl/bp_meta_slot.sv
// One pipeline slot of prediction metadata; kill beats stall beats load.
module bp_meta_slot
  import bp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_kill,
  input  logic       i_stall,
  input  pred_meta_t i_load,
  output pred_meta_t o_slot
);

  pred_meta_t r_slot;
  pred_meta_t w_slot_d;

  always_comb begin
    w_slot_d = r_slot;
    if (i_kill) begin
      w_slot_d.valid = 1'b0;
    end else if (!i_stall) begin
      w_slot_d = i_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else begin
      r_slot <= w_slot_d;
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries IF prediction metadata to EX, resolves branches there, drives redirect and
// the predictor write port, and keeps saturating branch/mispredict counters.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
);

  pred_meta_t w_if_meta;
  pred_meta_t w_id_meta;
  pred_meta_t w_ex_meta;
  pred_meta_t w_ex_load;

  logic w_id_kill;
  logic w_ex_kill;
  logic w_resolve;
  logic w_dir_miss;
  logic w_tgt_miss;
  logic w_mispredict;
  logic [31:0] w_redirect_pc;

  logic r_resolved;
  logic w_resolved_d;

  logic [1:0]  r_w_en;
  logic [1:0]  w_w_en_d;
  logic        r_br_in;
  logic [31:0] r_w_br_pc;
  logic [31:0] r_w_br_target;

  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  always_comb begin
    w_if_meta = '{
      valid:       bus.if_valid,
      pc:          bus.if_pc,
      pred:        bus.if_pred,
      pred_target: bus.if_pred_target,
      hit:         bus.if_hit
    };
  end

  // A stalled ID slot cannot advance, so EX takes a bubble instead.
  assign w_ex_load = bus.stall_id ? pred_meta_t'('0) : w_id_meta;

  assign w_id_kill = bus.flush_id | w_mispredict;
  assign w_ex_kill = bus.flush_ex | w_mispredict;

  bp_meta_slot u_id_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_kill  (w_id_kill),
    .i_stall (bus.stall_id),
    .i_load  (w_if_meta),
    .o_slot  (w_id_meta)
  );

  bp_meta_slot u_ex_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_kill  (w_ex_kill),
    .i_stall (bus.stall_ex),
    .i_load  (w_ex_load),
    .o_slot  (w_ex_meta)
  );

  always_comb begin
    w_resolve  = w_ex_meta.valid & bus.ex_is_br & ~r_resolved;
    w_dir_miss = bus.ex_taken != w_ex_meta.pred[PRED_TAKEN_BIT];
    w_tgt_miss = bus.ex_taken & w_ex_meta.pred[PRED_TAKEN_BIT] &
                 (bus.ex_target != w_ex_meta.pred_target);
    w_mispredict = w_resolve & (w_dir_miss | w_tgt_miss);
    w_redirect_pc = '0;
    if (w_mispredict) begin
      w_redirect_pc = bus.ex_taken ? bus.ex_target : seq_pc(w_ex_meta.pc);
    end
  end

  // Blocks a second update while stall_ex holds an already-resolved branch.
  always_comb begin
    w_resolved_d = r_resolved;
    if (w_ex_kill || !bus.stall_ex) begin
      w_resolved_d = 1'b0;
    end else if (w_resolve) begin
      w_resolved_d = 1'b1;
    end
  end

  always_comb begin
    w_w_en_d = '0;
    if (w_resolve) begin
      w_w_en_d[WEN_BHT] = 1'b1;
      // A not-taken hit also writes the BTB, to clear that entry.
      w_w_en_d[WEN_BTB] = bus.ex_taken | w_ex_meta.hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resolved    <= 1'b0;
      r_w_en        <= '0;
      r_br_in       <= 1'b0;
      r_w_br_pc     <= '0;
      r_w_br_target <= '0;
    end else begin
      r_resolved <= w_resolved_d;
      r_w_en     <= w_w_en_d;
      if (w_resolve) begin
        r_br_in       <= bus.ex_taken;
        r_w_br_pc     <= w_ex_meta.pc;
        r_w_br_target <= bus.ex_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_resolve && (r_br_cnt != '1)) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      end
      if (w_mispredict && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.mispredict  = w_mispredict;
  assign bus.redirect_pc = w_redirect_pc;
  assign bus.w_en        = r_w_en;
  assign bus.br_in       = r_br_in;
  assign bus.w_br_pc     = r_w_br_pc;
  assign bus.w_br_target = r_w_br_target;
  assign bus.br_cnt      = r_br_cnt;
  assign bus.miss_cnt    = r_miss_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit against an in-bench behavioural model;
// a second 3-bit-counter instance shares the stimulus to exercise counter saturation.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(32)) bus ();
  branch_resolve_unit_if #(.CNT_W(3))  bus_s ();

  branch_resolve_unit #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  branch_resolve_unit #(.CNT_W(3)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  assign bus_s.if_valid       = bus.if_valid;
  assign bus_s.if_pc          = bus.if_pc;
  assign bus_s.if_pred        = bus.if_pred;
  assign bus_s.if_pred_target = bus.if_pred_target;
  assign bus_s.if_hit         = bus.if_hit;
  assign bus_s.stall_id       = bus.stall_id;
  assign bus_s.stall_ex       = bus.stall_ex;
  assign bus_s.flush_id       = bus.flush_id;
  assign bus_s.flush_ex       = bus.flush_ex;
  assign bus_s.ex_is_br       = bus.ex_is_br;
  assign bus_s.ex_taken       = bus.ex_taken;
  assign bus_s.ex_target      = bus.ex_target;

  int n_checks = 0;
  int n_err    = 0;
  int wen_pulses = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit        valid;
    bit [31:0] pc;
    bit [1:0]  pred;
    bit [31:0] tgt;
    bit        hit;
    bit        done;  // this instruction already updated the predictor
  } rec_t;

  rec_t      m_id, m_ex;
  bit [1:0]  m_wen;
  bit        m_br_in;
  bit [31:0] m_wpc, m_wtgt;
  longint    m_br, m_miss;  // unbounded totals; saturation applied when comparing

  function automatic longint sat_to(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit m_resolve();
    return m_ex.valid && bus.ex_is_br && !m_ex.done;
  endfunction

  function automatic bit m_mis();
    if (!m_resolve()) return 1'b0;
    if (bus.ex_taken != m_ex.pred[1]) return 1'b1;
    return bus.ex_taken && (bus.ex_target != m_ex.tgt);
  endfunction

  function automatic bit [31:0] m_rpc();
    if (!m_mis()) return 32'h0;
    return bus.ex_taken ? bus.ex_target : m_ex.pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    rec_t nid, nex;
    bit res, mis;
    if (!rst_n) begin
      m_id = '0; m_ex = '0; m_wen = '0; m_br_in = 0; m_wpc = 0; m_wtgt = 0;
      m_br = 0; m_miss = 0;
    end else begin
      res = m_resolve();
      mis = m_mis();
      m_wen = 2'b00;
      if (res) begin
        m_wen[1] = 1'b1;
        m_wen[0] = bus.ex_taken || (m_ex.hit && !bus.ex_taken);
        m_br_in  = bus.ex_taken;
        m_wpc    = m_ex.pc;
        m_wtgt   = bus.ex_target;
        m_br++;
        if (mis) m_miss++;
      end
      nid = m_id;
      nex = m_ex;
      if (bus.flush_ex || mis) nex.valid = 1'b0;
      else if (bus.stall_ex) nex.done = m_ex.done || res;
      else begin
        nex = bus.stall_id ? rec_t'('0) : m_id;
        nex.done = 1'b0;
      end
      if (bus.flush_id || mis) nid.valid = 1'b0;
      else if (!bus.stall_id) begin
        nid = '{valid: bus.if_valid, pc: bus.if_pc, pred: bus.if_pred,
                tgt: bus.if_pred_target, hit: bus.if_hit, done: 1'b0};
      end
      m_id = nid;
      m_ex = nex;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (bus.w_en != 2'b00) wen_pulses++;
    if (chk_en) begin
      check("mispredict",   64'(bus.mispredict),   64'(m_mis()));
      check("redirect_pc",  64'(bus.redirect_pc),  64'(m_rpc()));
      check("w_en",         64'(bus.w_en),         64'(m_wen));
      check("br_in",        64'(bus.br_in),        64'(m_br_in));
      check("w_br_pc",      64'(bus.w_br_pc),      64'(m_wpc));
      check("w_br_target",  64'(bus.w_br_target),  64'(m_wtgt));
      check("br_cnt",       64'(bus.br_cnt),       64'(sat_to(m_br, 32)));
      check("miss_cnt",     64'(bus.miss_cnt),     64'(sat_to(m_miss, 32)));
      check("s_mispredict", 64'(bus_s.mispredict), 64'(m_mis()));
      check("s_w_en",       64'(bus_s.w_en),       64'(m_wen));
      check("s_br_cnt",     64'(bus_s.br_cnt),     64'(sat_to(m_br, 3)));
      check("s_miss_cnt",   64'(bus_s.miss_cnt),   64'(sat_to(m_miss, 3)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_valid = 0; bus.if_pc = 0; bus.if_pred = 0; bus.if_pred_target = 0; bus.if_hit = 0;
    bus.stall_id = 0; bus.stall_ex = 0; bus.flush_id = 0; bus.flush_ex = 0;
    bus.ex_is_br = 0; bus.ex_taken = 0; bus.ex_target = 0;
  endtask

  task automatic drive_if(input logic [31:0] pc, input logic [1:0] pred,
                          input logic [31:0] ptgt, input logic hit);
    bus.if_valid = 1; bus.if_pc = pc; bus.if_pred = pred;
    bus.if_pred_target = ptgt; bus.if_hit = hit;
  endtask

  // Push one branch to EX, resolve it, check the redirect and the following update.
  task automatic run_branch(input string nm, input logic [31:0] pc, input logic [1:0] pred,
                            input logic [31:0] ptgt, input logic hit, input logic taken,
                            input logic [31:0] tgt, input bit follow, input logic exp_mis,
                            input logic [31:0] exp_rpc, input logic [1:0] exp_wen);
    tick();
    drive_if(pc, pred, ptgt, hit);
    tick();
    if (follow) drive_if(pc + 32'd4, pred, ptgt, hit);
    else bus.if_valid = 0;
    tick();
    bus.if_valid = 0;
    bus.ex_is_br = 1; bus.ex_taken = taken; bus.ex_target = tgt;
    @(negedge clk);
    check({nm, "_mispredict"}, 64'(bus.mispredict), 64'(exp_mis));
    check({nm, "_redirect"},   64'(bus.redirect_pc), 64'(exp_rpc));
    tick();
    bus.ex_is_br = 0;
    @(negedge clk);
    check({nm, "_w_en"},      64'(bus.w_en),        64'(exp_wen));
    check({nm, "_br_in"},     64'(bus.br_in),       64'(taken));
    check({nm, "_w_br_pc"},   64'(bus.w_br_pc),     64'(pc));
    check({nm, "_w_br_tgt"},  64'(bus.w_br_target), 64'(tgt));
  endtask

  // Correctly predicted not-taken branch held in EX by stall_ex for 3 cycles.
  task automatic stall_branch(input bit chk_main, input longint exp_br, input longint exp_miss,
                              input longint exp_s_br);
    int p0;
    tick();
    drive_if(32'h400, 2'b00, 32'h500, 1'b0);
    tick();
    bus.if_valid = 0;
    tick();
    p0 = wen_pulses;
    bus.ex_is_br = 1; bus.ex_taken = 0; bus.ex_target = 32'h500; bus.stall_ex = 1;
    @(negedge clk);
    check("stall_mispredict", 64'(bus.mispredict), 64'd0);
    tick();
    @(negedge clk);
    check("stall_w_en", 64'(bus.w_en), 64'h2);
    tick();
    tick();
    bus.stall_ex = 0; bus.ex_is_br = 0;
    tick();
    tick();
    @(negedge clk);
    check("stall_pulses", 64'(wen_pulses - p0), 64'd1);
    if (chk_main) begin
      check("stall_br_cnt",   64'(bus.br_cnt),   64'(exp_br));
      check("stall_miss_cnt", 64'(bus.miss_cnt), 64'(exp_miss));
    end
    check("stall_s_br_cnt", 64'(bus_s.br_cnt), 64'(exp_s_br));
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    check("reset_w_en",     64'(bus.w_en),     64'd0);
    check("reset_br_cnt",   64'(bus.br_cnt),   64'd0);
    check("reset_miss_cnt", 64'(bus.miss_cnt), 64'd0);

    run_branch("t_ok", 32'h100, 2'b11, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0,
               1'b0, 32'h0, 2'b11);
    check("t_ok_br_cnt",   64'(bus.br_cnt),   64'd1);
    check("t_ok_miss_cnt", 64'(bus.miss_cnt), 64'd0);

    run_branch("t_nt", 32'h20, 2'b00, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1,
               1'b1, 32'h40, 2'b11);
    check("t_nt_miss_cnt", 64'(bus.miss_cnt), 64'd1);
    // The follower would mispredict too if it had survived into EX.
    #1;
    bus.ex_is_br = 1; bus.ex_taken = 1; bus.ex_target = 32'h44;
    #2;
    check("kill_mispredict", 64'(bus.mispredict), 64'd0);
    @(negedge clk);
    check("kill_w_en", 64'(bus.w_en), 64'd0);
    #1;
    bus.ex_is_br = 0; bus.ex_taken = 0;

    run_branch("t_tn", 32'h80, 2'b11, 32'h200, 1'b1, 1'b0, 32'h200, 1'b0,
               1'b1, 32'h84, 2'b11);
    run_branch("t_tgt", 32'h180, 2'b11, 32'h300, 1'b1, 1'b1, 32'h304, 1'b0,
               1'b1, 32'h304, 2'b11);
    check("t_tgt_br_cnt",   64'(bus.br_cnt),   64'd4);
    check("t_tgt_miss_cnt", 64'(bus.miss_cnt), 64'd3);

    stall_branch(1'b1, 5, 3, 5);

    for (int i = 0; i < 800; i++) begin
      bus.if_valid       = ($urandom_range(0, 3) != 0);
      bus.if_pc          = 32'($urandom_range(0, 255)) << 2;
      bus.if_pred        = 2'($urandom);
      bus.if_pred_target = ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300;
      bus.if_hit         = 1'($urandom);
      bus.stall_id       = ($urandom_range(0, 4) == 0);
      bus.stall_ex       = ($urandom_range(0, 4) == 0);
      bus.flush_id       = ($urandom_range(0, 19) == 0);
      bus.flush_ex       = ($urandom_range(0, 19) == 0);
      bus.ex_is_br       = 1'($urandom);
      bus.ex_taken       = 1'($urandom);
      bus.ex_target      = ($urandom_range(0, 1) != 0) ? m_ex.tgt : 32'h304;
      tick();
    end
    idle();
    bus.flush_id = 1; bus.flush_ex = 1;
    tick();
    idle();
    tick();
    stall_branch(1'b0, 0, 0, 7);

    // Asynchronous reset while a mispredicting branch sits in EX.
    tick();
    drive_if(32'h600, 2'b00, 32'h0, 1'b0);
    tick();
    bus.if_valid = 0;
    tick();
    bus.ex_is_br = 1; bus.ex_taken = 1; bus.ex_target = 32'h700;
    @(negedge clk);
    check("pre_rst_mispredict", 64'(bus.mispredict),  64'd1);
    check("pre_rst_redirect",   64'(bus.redirect_pc), 64'h700);
    #1;
    rst_n = 0;
    #1;
    check("rst_mispredict", 64'(bus.mispredict),  64'd0);
    check("rst_redirect",   64'(bus.redirect_pc), 64'd0);
    check("rst_w_en",       64'(bus.w_en),        64'd0);
    check("rst_br_cnt",     64'(bus.br_cnt),      64'd0);
    check("rst_miss_cnt",   64'(bus.miss_cnt),    64'd0);
    check("rst_w_br_pc",    64'(bus.w_br_pc),     64'd0);
    check("rst_s_br_cnt",   64'(bus_s.br_cnt),    64'd0);
    repeat (2) tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_w_en", 64'(bus.w_en), 64'd0);
    end
    idle();
    tick();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
